simon_autoplayer: RTL and testbench

Automated player that drives the Simon game from the opposite side of its switch/button interface. It reads mode_leds and pattern_leds, generates the pattern switches and the pclk button press, and records the playback sequence into a local memory. It then replays that sequence in repeat mode, inserts a fresh pattern each input round, and counts completed rounds until the game reaches done. It is used for board self-test and soak regression against Simon.

---
 rtl/simon_pkg.sv | 25 ++
 rtl/simon_autoplayer_if.sv | 21 ++
 rtl/simon_press_gen.sv | 57 +++++
 rtl/simon_autoplayer.sv | 175 +++++++++++++++++
 tb/tb_simon_autoplayer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared constants, state encoding and LFSR helper for the Simon autoplayer.
package simon_pkg;

  localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
  localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
  localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
  localparam logic [2:0] LED_MODE_DONE     = 3'b111;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    StIdle,
    StGen,
    StCapture,
    StReplay,
    StHalt,
    StWaitAck
  } player_state_e;

  function automatic logic [7:0] lfsr_step(logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/simon_autoplayer_if.sv
// Switch/button/LED connection between the autoplayer (master) and the Simon game (slave).
interface simon_autoplayer_if;
  logic [2:0] mode_leds;
  logic [3:0] pattern_leds;
  logic [3:0] pattern;
  logic       pclk;

  modport master (
    input  mode_leds,
    input  pattern_leds,
    output pattern,
    output pclk
  );

  modport slave (
    output mode_leds,
    output pattern_leds,
    input  pattern,
    input  pclk
  );
endinterface

// File: rtl/simon_press_gen.sv
// Button-press timer: setup low, press high, release low, settle, then a one-cycle ack.
module simon_press_gen #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned PRESS_CYCLES  = 3,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic sysclk,
  input  logic rst,
  input  logic req,
  output logic pclk,
  output logic ack
);

  localparam int unsigned Total = SETUP_CYCLES + 2 * PRESS_CYCLES + SETTLE_CYCLES;
  localparam int unsigned CntW  = $clog2(Total + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            run_q, run_d;
  logic            pclk_q, pclk_d;
  logic            ack_q, ack_d;

  // cnt counts cycles since the req cycle, so the req cycle itself is setup cycle 0.
  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    if (run_q) begin
      cnt_d = cnt_q + 1'b1;
    end else if (req) begin
      run_d = 1'b1;
      cnt_d = CntW'(1);
    end
    pclk_d = run_d && (cnt_d >= CntW'(SETUP_CYCLES)) &&
             (cnt_d < CntW'(SETUP_CYCLES + PRESS_CYCLES));
    ack_d  = run_d && (cnt_d == CntW'(Total));
    if (ack_d) begin
      run_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      pclk_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      pclk_q <= pclk_d;
      ack_q  <= ack_d;
    end
  end

  assign pclk = pclk_q;
  assign ack  = ack_q;

endmodule

// File: rtl/simon_autoplayer.sv
// Plays Simon from the switch side: generates a pattern, captures playback, replays it,
// and counts completed rounds until the game reports done.
module simon_autoplayer
  import simon_pkg::*;
#(
  parameter int unsigned MAX_SEQ       = 64,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned PRESS_CYCLES  = 3,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                      sysclk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      inject_err,
  simon_autoplayer_if.master        game,
  output logic [6:0]                rounds,
  output logic                      busy,
  output logic                      game_over,
  output logic                      error
);

  localparam int unsigned IdxW  = $clog2(MAX_SEQ) + 1;
  localparam int unsigned AddrW = $clog2(MAX_SEQ);

  player_state_e   state_q, ret_q, ack_next;
  logic [7:0]      lfsr_q;
  logic [IdxW-1:0] idx_q, len_q;
  logic [3:0]      pattern_q;
  logic            req_q, ack;
  logic [6:0]      rounds_q;
  logic            busy_q, game_over_q, error_q;
  logic            ack_done;

  logic [3:0]       mem [MAX_SEQ];
  logic [AddrW-1:0] addr;
  logic [3:0]       rd_data, replay_pat, gen_pat;

  assign addr       = idx_q[AddrW-1:0];
  assign rd_data    = mem[addr];
  assign replay_pat = (inject_err && (idx_q == len_q - 1'b1)) ?
                      {rd_data[2:0], rd_data[3]} : rd_data;
  assign gen_pat    = 4'b0001 << lfsr_q[1:0];

  always_ff @(posedge sysclk) begin
    if (state_q == StCapture) begin
      mem[addr] <= game.pattern_leds;
    end
  end

  // Where the game's response after a press leads; anything unlisted halts with error.
  always_comb begin
    ack_next = StHalt;
    ack_done = 1'b0;
    if (game.mode_leds == LED_MODE_DONE && ret_q != StCapture) begin
      ack_done = 1'b1;
    end else begin
      case (ret_q)
        StGen: begin
          if (game.mode_leds == LED_MODE_PLAYBACK)   ack_next = StCapture;
          else if (game.mode_leds == LED_MODE_INPUT) ack_next = StGen;
        end
        StCapture: begin
          if (game.mode_leds == LED_MODE_PLAYBACK && idx_q != IdxW'(MAX_SEQ)) begin
            ack_next = StCapture;
          end else if (game.mode_leds == LED_MODE_REPEAT) begin
            ack_next = StReplay;
          end
        end
        StReplay: begin
          if (game.mode_leds == LED_MODE_REPEAT && idx_q < len_q)      ack_next = StReplay;
          else if (game.mode_leds == LED_MODE_INPUT && idx_q == len_q) ack_next = StGen;
        end
        default: ack_next = StHalt;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ret_q       <= StIdle;
      lfsr_q      <= LFSR_SEED;
      idx_q       <= '0;
      len_q       <= '0;
      pattern_q   <= '0;
      req_q       <= 1'b0;
      rounds_q    <= '0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      req_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && game.mode_leds == LED_MODE_INPUT) begin
            pattern_q <= gen_pat;
            lfsr_q    <= lfsr_step(lfsr_q);
            req_q     <= 1'b1;
            ret_q     <= StGen;
            busy_q    <= 1'b1;
            state_q   <= StWaitAck;
          end
        end
        StGen: begin
          pattern_q <= gen_pat;
          lfsr_q    <= lfsr_step(lfsr_q);
          req_q     <= 1'b1;
          ret_q     <= StGen;
          state_q   <= StWaitAck;
        end
        StCapture: begin
          idx_q     <= idx_q + 1'b1;
          pattern_q <= '0;
          req_q     <= 1'b1;
          ret_q     <= StCapture;
          state_q   <= StWaitAck;
        end
        StReplay: begin
          pattern_q <= replay_pat;
          idx_q     <= idx_q + 1'b1;
          req_q     <= 1'b1;
          ret_q     <= StReplay;
          state_q   <= StWaitAck;
        end
        StWaitAck: begin
          if (ack) begin
            state_q <= ack_next;
            if (ack_next == StHalt) begin
              pattern_q   <= '0;
              busy_q      <= 1'b0;
              game_over_q <= game_over_q | ack_done;
              error_q     <= error_q | !ack_done;
            end
            if (ret_q == StCapture && ack_next == StReplay) begin
              len_q <= idx_q;
              idx_q <= '0;
            end else if (ret_q == StGen && ack_next == StCapture) begin
              idx_q <= '0;
            end
            if (ret_q == StReplay && ack_next == StGen && rounds_q != 7'd127) begin
              rounds_q <= rounds_q + 1'b1;
            end
          end
        end
        StHalt: ;
        default: begin
          state_q   <= StHalt;
          pattern_q <= '0;
          busy_q    <= 1'b0;
          error_q   <= 1'b1;
        end
      endcase
    end
  end

  simon_press_gen #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .PRESS_CYCLES (PRESS_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_press_gen (
    .sysclk(sysclk),
    .rst   (rst),
    .req   (req_q),
    .pclk  (game.pclk),
    .ack   (ack)
  );

  assign game.pattern = pattern_q;
  assign rounds       = rounds_q;
  assign busy         = busy_q;
  assign game_over    = game_over_q;
  assign error        = error_q;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Bench for simon_autoplayer: a behavioural Simon model plus a press-pattern scoreboard.
module tb_simon_autoplayer;
  import simon_pkg::*;

  localparam int PRESS = 3;

  logic sysclk = 1'b0;
  logic rst, start, inject_err;
  logic [6:0] rounds1, rounds2;
  logic busy1, busy2, go1, go2, err1, err2;

  simon_autoplayer_if g1 ();
  simon_autoplayer_if g2 ();

  simon_autoplayer u_dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .start     (start),
    .inject_err(inject_err),
    .game      (g1),
    .rounds    (rounds1),
    .busy      (busy1),
    .game_over (go1),
    .error     (err1)
  );

  simon_autoplayer #(.MAX_SEQ(4)) u_dut_small (
    .sysclk    (sysclk),
    .rst       (rst),
    .start     (start),
    .inject_err(inject_err),
    .game      (g2),
    .rounds    (rounds2),
    .busy      (busy2),
    .game_over (go2),
    .error     (err2)
  );

  always #5 sysclk = ~sysclk;

  int tests = 0;
  int fails = 0;
  int press_cnt = 0;
  int press2 = 0;
  logic [3:0] exp_q[$];

  logic [3:0] seq[$];
  int pos = 0;
  int cap = 3;
  bit reject = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic simon_press(input logic [3:0] pat);
    case (g1.mode_leds)
      LED_MODE_INPUT: begin
        if (!reject) begin
          if (seq.size() == cap) begin
            g1.mode_leds = LED_MODE_DONE;
          end else begin
            seq.push_back(pat);
            pos = 0;
            g1.mode_leds = LED_MODE_PLAYBACK;
            g1.pattern_leds = seq[0];
          end
        end
      end
      LED_MODE_PLAYBACK: begin
        pos++;
        if (pos == seq.size()) begin
          g1.mode_leds = LED_MODE_REPEAT;
          g1.pattern_leds = 4'h0;
          pos = 0;
        end else begin
          g1.pattern_leds = seq[pos];
        end
      end
      LED_MODE_REPEAT: begin
        if (pat != seq[pos]) begin
          g1.mode_leds = LED_MODE_DONE;
        end else begin
          pos++;
          if (pos == seq.size()) g1.mode_leds = LED_MODE_INPUT;
        end
      end
      default: ;
    endcase
  endtask

  task automatic simon_reset(input int new_cap, input bit new_reject);
    seq.delete();
    pos = 0;
    cap = new_cap;
    reject = new_reject;
    g1.mode_leds = LED_MODE_INPUT;
    g1.pattern_leds = 4'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge sysclk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge sysclk);
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
  endtask

  // Simon model for the full-size player.
  initial begin
    bit p;
    p = 1'b0;
    forever begin
      @(negedge sysclk);
      if (!rst && g1.pclk && !p) simon_press(g1.pattern);
      p = g1.pclk;
    end
  end

  // Small player's game sits in playback forever after the first press.
  initial begin
    bit p;
    p = 1'b0;
    forever begin
      @(negedge sysclk);
      if (!rst && g2.pclk && !p) begin
        press2++;
        g2.mode_leds = LED_MODE_PLAYBACK;
        g2.pattern_leds = 4'h5;
      end
      p = g2.pclk;
    end
  end

  // Scoreboard monitor: every press rise pops one expected pattern; high width is checked.
  initial begin
    bit prev;
    int hi;
    logic [3:0] e;
    prev = 1'b0;
    hi = 0;
    forever begin
      @(negedge sysclk);
      if (rst) begin
        prev = 1'b0;
        hi = 0;
      end else begin
        if (g1.pclk && !prev) begin
          press_cnt++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_press: pattern %b, no press expected", g1.pattern);
          end else begin
            e = exp_q.pop_front();
            check("press_pattern", 32'(g1.pattern), 32'(e));
          end
        end
        if (g1.pclk) begin
          hi++;
        end else if (prev) begin
          check("press_width", 32'(hi), 32'(PRESS));
          hi = 0;
        end
        prev = g1.pclk;
      end
    end
  end

  logic [3:0] vec_a [16] = '{4'b0010, 4'b0000, 4'b0010,
                             4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b0100,
                             4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0010,
                             4'b0100};
  logic [3:0] vec_b [8]  = '{4'b0010, 4'b0000, 4'b0010,
                             4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b1000};
  logic [3:0] vec_c [3]  = '{4'b0010, 4'b0100, 4'b0010};

  initial begin
    bit any_pclk;
    start = 1'b0;
    inject_err = 1'b0;
    g2.mode_leds = 3'b000;
    g2.pattern_leds = 4'h0;
    simon_reset(3, 1'b0);
    rst = 1'b1;
    @(negedge sysclk);
    check("rst_pattern", 32'(g1.pattern), 32'(0));
    check("rst_pclk", 32'(g1.pclk), 32'(0));
    @(negedge sysclk);
    rst = 1'b0;

    // Idle with no start.
    any_pclk = 1'b0;
    repeat (20) begin
      @(negedge sysclk);
      any_pclk |= g1.pclk;
    end
    check("idle_pclk_quiet", 32'(any_pclk), 32'(0));
    check("idle_outputs", 32'({g1.pattern, rounds1, busy1, go1, err1}), 32'(0));

    // Three full rounds, then the game reports done on the fourth input.
    foreach (vec_a[i]) exp_q.push_back(vec_a[i]);
    pulse_start();
    check("first_pattern", 32'(g1.pattern), 32'(4'b0010));
    check("busy_after_start", 32'(busy1), 32'(1));
    check("pclk_setup0", 32'(g1.pclk), 32'(0));
    @(negedge sysclk);
    check("pclk_setup1", 32'(g1.pclk), 32'(0));
    @(negedge sysclk);
    check("pclk_rise", 32'(g1.pclk), 32'(1));
    for (int i = 0; i < 3000 && !go1; i++) @(negedge sysclk);
    check("a_game_over", 32'(go1), 32'(1));
    check("a_rounds", 32'(rounds1), 32'(3));
    check("a_error", 32'(err1), 32'(0));
    check("a_busy", 32'(busy1), 32'(0));
    repeat (30) @(negedge sysclk);
    check("a_pattern_halt", 32'(g1.pattern), 32'(0));
    check("a_sb_drained", 32'(exp_q.size()), 32'(0));

    // Corrupted final guess in round two.
    simon_reset(8, 1'b0);
    do_reset();
    exp_q.delete();
    foreach (vec_b[i]) exp_q.push_back(vec_b[i]);
    pulse_start();
    for (int i = 0; i < 1000 && rounds1 != 7'd1; i++) @(negedge sysclk);
    check("b_round1", 32'(rounds1), 32'(1));
    inject_err = 1'b1;
    for (int i = 0; i < 1000 && !go1; i++) @(negedge sysclk);
    check("b_game_over", 32'(go1), 32'(1));
    check("b_rounds", 32'(rounds1), 32'(1));
    check("b_busy", 32'(busy1), 32'(0));
    check("b_error", 32'(err1), 32'(0));
    repeat (40) @(negedge sysclk);
    check("b_sb_drained", 32'(exp_q.size()), 32'(0));
    inject_err = 1'b0;

    // Game keeps rejecting: repeated generation with advancing LFSR, no rounds.
    simon_reset(8, 1'b1);
    do_reset();
    exp_q.delete();
    press_cnt = 0;
    foreach (vec_c[i]) exp_q.push_back(vec_c[i]);
    pulse_start();
    for (int i = 0; i < 500 && press_cnt < 3; i++) @(negedge sysclk);
    check("c_presses", 32'(press_cnt), 32'(3));
    check("c_rounds", 32'(rounds1), 32'(0));
    check("c_busy", 32'(busy1), 32'(1));

    // Reset while the button is held.
    simon_reset(8, 1'b0);
    do_reset();
    exp_q.delete();
    exp_q.push_back(4'b0010);
    pulse_start();
    for (int i = 0; i < 50 && !g1.pclk; i++) @(negedge sysclk);
    check("d_pclk_high", 32'(g1.pclk), 32'(1));
    rst = 1'b1;
    #1;
    check("d_pclk_cut", 32'(g1.pclk), 32'(0));
    check("d_busy_cut", 32'(busy1), 32'(0));
    check("d_pattern_cut", 32'(g1.pattern), 32'(0));
    @(negedge sysclk);
    rst = 1'b0;
    repeat (20) @(negedge sysclk);
    check("d_still_idle", 32'(busy1), 32'(0));

    // Small player overflows; the big one ignores start outside input mode.
    g1.mode_leds = 3'b000;
    g2.mode_leds = LED_MODE_INPUT;
    do_reset();
    press2 = 0;
    pulse_start();
    for (int i = 0; i < 500 && !err2; i++) @(negedge sysclk);
    check("e_error", 32'(err2), 32'(1));
    check("e_presses", 32'(press2), 32'(5));
    check("e_busy", 32'(busy2), 32'(0));
    check("e_game_over", 32'(go2), 32'(0));
    check("e_rounds", 32'(rounds2), 32'(0));
    check("e_ignored_start", 32'(busy1), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
